// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the
// zero-extending helpers used for the bit-time counter compares.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int BP_W   = 29;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    // Counter value at which the middle of the start bit is reached.
    function automatic logic [CNT_W-1:0] half_period(input logic [BP_W-1:0] bp);
        return {4'h0, bp[BP_W-1:1]};
    endfunction

    function automatic logic [CNT_W-1:0] full_period(input logic [BP_W-1:0] bp);
        return {3'h0, bp};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection on the start
// bit, frame-error reporting and break (line-low) handling.
module uart_rx
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              locked_i,
    input  logic [BP_W-1:0]   bitperiod_i,
    output logic [DATA_W-1:0] dout_bo,
    output logic              rx_done_tick_o,
    output logic              frame_err_o
);

    logic rx_sync;

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  clk_counter_q, clk_counter_d;
    logic [2:0]        bit_counter_q, bit_counter_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rx_done_q, rx_done_d;
    logic              frame_err_q, frame_err_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_sync)
    );

    always_comb begin
        state_d       = state_q;
        clk_counter_d = clk_counter_q;
        bit_counter_d = bit_counter_q;
        shreg_d       = shreg_q;
        dout_d        = dout_q;
        rx_done_d     = 1'b0;
        frame_err_d   = 1'b0;

        // Losing clock lock aborts any frame in progress silently.
        if (state_q != ST_IDLE && !locked_i) begin
            state_d       = ST_IDLE;
            clk_counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_sync && locked_i) begin
                        state_d       = ST_START;
                        clk_counter_d = '0;
                    end
                end
                ST_START: begin
                    clk_counter_d = clk_counter_q + 1'b1;
                    if (clk_counter_q == half_period(bitperiod_i)) begin
                        clk_counter_d = '0;
                        if (!rx_sync) begin
                            state_d       = ST_DATA;
                            bit_counter_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    clk_counter_d = clk_counter_q + 1'b1;
                    if (clk_counter_q == full_period(bitperiod_i)) begin
                        clk_counter_d = '0;
                        shreg_d       = {rx_sync, shreg_q[DATA_W-1:1]};
                        bit_counter_d = bit_counter_q + 3'd1;
                        if (bit_counter_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    clk_counter_d = clk_counter_q + 1'b1;
                    if (clk_counter_q == full_period(bitperiod_i)) begin
                        clk_counter_d = '0;
                        if (rx_sync) begin
                            dout_d    = shreg_q;
                            rx_done_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            clk_counter_q <= '0;
            bit_counter_q <= '0;
            shreg_q       <= '0;
            dout_q        <= '0;
            rx_done_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_counter_q <= clk_counter_d;
            bit_counter_q <= bit_counter_d;
            shreg_q       <= shreg_d;
            dout_q        <= dout_d;
            rx_done_q     <= rx_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign dout_bo        = dout_q;
    assign rx_done_tick_o = rx_done_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of whole frames plus directed
// sequences for latency, glitch, break, lock loss and mid-frame reset.
module tb_uart_rx;

    localparam int T = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        locked_i;
    logic [28:0] bitperiod_i;
    logic [7:0]  dout_bo;
    logic        rx_done_tick_o;
    logic        frame_err_o;

    int checkCount = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int errCount   = 0;
    logic [7:0] lastDout = 8'h00;

    typedef struct {
        logic [7:0] data;
        int         stopBits;
        logic       stopLevel;
        int         expDone;
        int         expErr;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs[5];

    uart_rx dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .locked_i       (locked_i),
        .bitperiod_i    (bitperiod_i),
        .dout_bo        (dout_bo),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulse monitor: records every tick/error seen on the outputs.
    always @(negedge clk_i) begin
        if (rx_done_tick_o === 1'b1 || frame_err_o === 1'b1) begin
            checkOutput("pulses_exclusive", int'(rx_done_tick_o & frame_err_o), 0);
        end
        if (rx_done_tick_o === 1'b1) begin
            doneCount++;
            lastDout = dout_bo;
        end
        if (frame_err_o === 1'b1) begin
            errCount++;
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input int stopBits, input logic stopLevel);
        rx_i = 1'b0;
        repeat (T) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            repeat (T) @(negedge clk_i);
        end
        rx_i = stopLevel;
        repeat (T * stopBits) @(negedge clk_i);
    endtask

    task automatic sendPartial(input logic [7:0] data, input int nBits);
        rx_i = 1'b0;
        repeat (T) @(negedge clk_i);
        for (int i = 0; i < nBits; i++) begin
            rx_i = data[i];
            repeat (T) @(negedge clk_i);
        end
    endtask

    task automatic idleLine(input int cycles);
        rx_i = 1'b1;
        repeat (cycles) @(negedge clk_i);
    endtask

    task automatic checkFrame(input string name, input logic [7:0] data, input logic [7:0] expDout);
        int d0;
        int e0;
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(data, 1, 1'b1);
        idleLine(2);
        checkOutput({name, "_ticks"}, doneCount - d0, 1);
        checkOutput({name, "_errs"}, errCount - e0, 0);
        checkOutput({name, "_dout"}, int'(dout_bo), int'(expDout));
    endtask

    initial begin
        int d0;
        int e0;
        int cyc;

        vecs[0] = '{8'h00, 2, 1'b1, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 2, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'h3C, 2, 1'b1, 1, 0, 8'h3C};
        vecs[3] = '{8'h01, 1, 1'b1, 1, 0, 8'h01};
        vecs[4] = '{8'h99, 1, 1'b0, 0, 1, 8'h01};

        rst_i       = 1'b1;
        rx_i        = 1'b1;
        locked_i    = 1'b1;
        bitperiod_i = 29'd9;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_dout", int'(dout_bo), 0);
        checkOutput("reset_tick", int'(rx_done_tick_o), 0);
        checkOutput("reset_err", int'(frame_err_o), 0);
        rst_i = 1'b0;
        idleLine(5);

        $display("[TB] latency test, 0xA5");
        d0 = doneCount;
        e0 = errCount;
        cyc = 0;
        fork
            applyStimulus(8'hA5, 1, 1'b1);
            begin
                while (rx_done_tick_o !== 1'b1 && cyc < 300) begin
                    @(negedge clk_i);
                    cyc++;
                end
                checkOutput("latency_cycles", cyc, 98);
                checkOutput("latency_dout", int'(dout_bo), 8'hA5);
                @(negedge clk_i);
                checkOutput("tick_width", int'(rx_done_tick_o), 0);
            end
        join
        idleLine(2);
        checkOutput("a5_ticks", doneCount - d0, 1);
        checkOutput("a5_errs", errCount - e0, 0);

        $display("[TB] table-driven frames");
        for (int v = 0; v < 5; v++) begin
            d0 = doneCount;
            e0 = errCount;
            applyStimulus(vecs[v].data, vecs[v].stopBits, vecs[v].stopLevel);
            checkOutput($sformatf("vec%0d_ticks", v), doneCount - d0, vecs[v].expDone);
            checkOutput($sformatf("vec%0d_errs", v), errCount - e0, vecs[v].expErr);
            checkOutput($sformatf("vec%0d_dout", v), int'(dout_bo), int'(vecs[v].expDout));
            if (vecs[v].expDone == 1) begin
                checkOutput($sformatf("vec%0d_lastdout", v), int'(lastDout), int'(vecs[v].expDout));
            end
        end
        idleLine(3 * T);

        $display("[TB] start glitch");
        d0 = doneCount;
        e0 = errCount;
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        idleLine(3 * T);
        checkOutput("glitch_ticks", doneCount - d0, 0);
        checkOutput("glitch_errs", errCount - e0, 0);
        checkFrame("after_glitch", 8'h5A, 8'h5A);

        $display("[TB] stop bit low with break");
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(8'h81, 1, 1'b0);
        repeat (50) @(negedge clk_i);
        idleLine(15 * T);
        checkOutput("break_errs", errCount - e0, 1);
        checkOutput("break_ticks", doneCount - d0, 0);
        checkOutput("break_dout", int'(dout_bo), 8'h5A);
        checkFrame("after_break", 8'h42, 8'h42);

        $display("[TB] lock loss during data bit 4");
        d0 = doneCount;
        e0 = errCount;
        sendPartial(8'h77, 4);
        rx_i = 1'b1;
        repeat (T / 2) @(negedge clk_i);
        locked_i = 1'b0;
        repeat (T / 2) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (T) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (T) @(negedge clk_i);
        rx_i = 1'b0;
        repeat (T) @(negedge clk_i);
        idleLine(3 * T);
        checkOutput("unlock_ticks", doneCount - d0, 0);
        checkOutput("unlock_errs", errCount - e0, 0);
        checkOutput("unlock_dout", int'(dout_bo), 8'h42);
        locked_i = 1'b1;
        idleLine(T);
        checkFrame("after_unlock", 8'h11, 8'h11);

        $display("[TB] reset mid-frame with line low");
        d0 = doneCount;
        e0 = errCount;
        sendPartial(8'hC3, 3);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("midrst_dout", int'(dout_bo), 0);
        checkOutput("midrst_tick", int'(rx_done_tick_o), 0);
        checkOutput("midrst_err", int'(frame_err_o), 0);
        checkFrame("after_reset", 8'hC3, 8'hC3);
        checkOutput("midrst_total_ticks", doneCount - d0, 1);
        checkOutput("midrst_total_errs", errCount - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 clk_i  input  1  system clock; all logic on the rising edge.
REQ-002 rst_i  input  1  synchronous, active-high reset.
REQ-003 rx_i  input  1  asynchronous serial line; idle high.
REQ-004 locked_i  input  1  clock-locked enable; the receiver is armed only while high.
REQ-005 bitperiod_i  input  29  bit time minus one, in clk_i cycles (T = bitperiod_i+1); held stable during a frame; legal minimum 3.
REQ-006 dout_bo  output  8  last correctly framed byte; holds its value until the next good frame.
REQ-007 rx_done_tick_o  output  1  one-cycle pulse; dout_bo is valid in the same cycle.
REQ-008 frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, then a stop bit (1); no parity.
REQ-010 rx_i SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-011 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; a 32-bit clk_counter and a 3-bit bit_counter.
REQ-012 IDLE: when rx_sync==0 and locked_i==1, go to START with clk_counter=0.
REQ-013 START: increment clk_counter; at clk_counter=={4'h0,bitperiod_i[28:1]} (mid start bit), if rx_sync==0 go to DATA with clk_counter=0 and bit_counter=0; otherwise treat it as a glitch and return to IDLE with no pulse.
REQ-014 DATA: increment clk_counter; at clk_counter=={3'h0,bitperiod_i}, shift rx_sync into shreg[7] (right shift) and clear clk_counter; after the 8th sample (bit_counter==7), go to STOP.
REQ-015 STOP: at clk_counter=={3'h0,bitperiod_i}, if rx_sync==1, load dout_bo<=shreg, pulse rx_done_tick_o, go to IDLE; otherwise pulse frame_err_o, leave dout_bo unchanged, go to WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_sync==1, then go to IDLE; this covers a break condition and prevents a false start.
REQ-017 locked_i==0 in any non-IDLE state: return to IDLE on the next edge, no pulses, dout_bo unchanged.
REQ-018 rx_done_tick_o and frame_err_o SHALL default to 0 every cycle and are never high together.
REQ-019 Sampling point: mid-bit; latency from the rx_i falling edge to rx_done_tick_o SHALL be 3 + bitperiod_i[28:1] + 1 + 9*T cycles.
REQ-020 Stop bits longer than 1 (e.g. the 2-bit-time stop from uart_tx) SHALL be accepted; the next start SHALL be detected as soon as IDLE sees rx_sync==0.

Reset
REQ-021 rst_i SHALL set: state=IDLE, synchronizer flops=1, shreg=0, dout_bo=0, clk_counter=0, bit_counter=0, rx_done_tick_o=0, frame_err_o=0.
REQ-022 Reset mid-frame SHALL discard the partial byte with no pulse; after release, a line still low SHALL be treated as a new start.

Structure
REQ-023 State encodings (ST_IDLE..ST_WAIT_HIGH) SHALL live in a shared uart package header also usable by uart_tx.
REQ-024 The 2-flop synchronizer SHALL be one sub-module, sync_2ff, with a reset value parameter (1 here).
REQ-025 Counter compare widths SHALL be zero-extended explicitly; no truncating compares.

Verification
REQ-026 bitperiod_i=9, send 0xA5 with a 1-bit stop -> rx_done_tick_o high exactly one cycle, 98 clocks after the falling edge; dout_bo=0xA5; frame_err_o never high.
REQ-027 Loopback from uart_tx (bitperiod_i=9), bytes 0x00, 0xFF, 0x3C back-to-back -> three ticks, dout_bo sequence 0x00, 0xFF, 0x3C.
REQ-028 Low glitch of 3 clocks on rx_i (bitperiod_i=9) -> return to IDLE, no pulses; next valid frame 0x5A received correctly.
REQ-029 Frame 0x81 with stop bit low, line held low 50 clocks -> one frame_err_o pulse, dout_bo unchanged, no start until rx_i is high again; then 0x42 received.
REQ-030 locked_i deasserted during data bit 4 of 0x77 -> no pulses, back in IDLE; with locked_i=1, next frame 0x11 -> dout_bo=0x11.
REQ-031 rst_i asserted for one cycle mid-frame -> all outputs at reset values; next frame 0xC3 received correctly.
